// File: rtl/multicycle_main_controller_pkg.sv
// Shared encodings for the multicycle RV32I main controller: states, opcodes, select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_main_controller_pkg;

   // ALUOp codes; values must match the ALU controller's decode.
   typedef enum logic [1:0] {
      ALUOP_S_T = 2'b00,   // add
      ALUOP_B_T = 2'b01,   // sub (branch compare)
      ALUOP_R_T = 2'b10,   // decode funct fields, R-type
      ALUOP_I_T = 2'b11    // decode funct fields, I-type
   } aluop_e;

   // Controller states; encodings 14 and 15 are unused and recover to FETCH.
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALR1    = 4'd11,
      ST_JALR2    = 4'd12,
      ST_LUI      = 4'd13
   } state_e;

   // Major opcodes (instr[6:0]).
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Branch func3 values that the core supports.
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   // Immediate format selects.
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Result mux selects.
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   // ALU operand selects.
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;
   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Immediate format implied by the opcode; unknown opcodes fall back to I.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      logic [2:0] imm;
      imm = IMM_I;
      case (op)
         OP_LOAD, OP_ITYPE, OP_JALR: imm = IMM_I;
         OP_STORE:                   imm = IMM_S;
         OP_BRANCH:                  imm = IMM_B;
         OP_JAL:                     imm = IMM_J;
         OP_LUI:                     imm = IMM_U;
         default:                    imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/multicycle_main_controller_branch_cond.sv
// Branch condition evaluation from func3 and the ALU subtract flags.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module multicycle_main_controller_branch_cond (
   input  logic [2:0] func3,
   input  logic       zero,
   input  logic       neg,
   output logic       take,
   output logic       bad
);
   import multicycle_main_controller_pkg::*;

   // Signed compare uses the sign of A-B only; overflow is deliberately ignored.
   always_comb begin
      take = 1'b0;
      bad  = 1'b0;
      case (func3)
         F3_BEQ:  take = zero;
         F3_BNE:  take = ~zero;
         F3_BLT:  take = neg;
         F3_BGE:  take = ~neg;
         default: bad  = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Latency: 3 (branch, lui) to 5 (lw, jalr) cycles per instruction; outputs are Moore decode of state.
// Backpressure: none; the sequence never stalls, reset low aborts the instruction immediately.
module multicycle_main_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       zero,
   input  logic       neg,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       illegal
);
   import multicycle_main_controller_pkg::*;

   state_e state_q;
   state_e state_d;
   aluop_e alu_op;
   logic   br_take;
   logic   br_bad;
   logic   pc_write_raw;
   logic   mem_write_raw;
   logic   ir_write_raw;
   logic   reg_write_raw;
   logic   illegal_raw;

   multicycle_main_controller_branch_cond u_branch_cond (
      .func3 (func3),
      .zero  (zero),
      .neg   (neg),
      .take  (br_take),
      .bad   (br_bad)
   );

   // State register; reset low forces FETCH without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore output decode; anything not named in a state stays 0.
   always_comb begin
      state_d       = ST_FETCH;
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_REGB;
      alu_op        = ALUOP_S_T;
      case (state_q)
         ST_FETCH: begin
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            ALUSrcA      = SRCA_PC;
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALURESULT;
            state_d      = ST_DECODE;
         end
         ST_DECODE: begin
            // Precompute OldPC+imm so branch/jal targets sit in ALUOut.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = ST_MEMADR;
               OP_RTYPE:          state_d = ST_EXECR;
               OP_ITYPE:          state_d = ST_EXECI;
               OP_BRANCH:         state_d = ST_BRANCH;
               OP_JAL:            state_d = ST_JAL;
               OP_JALR:           state_d = ST_JALR1;
               OP_LUI:            state_d = ST_LUI;
               default: begin
                  illegal_raw = 1'b1;
                  state_d     = ST_FETCH;
               end
            endcase
         end
         ST_MEMADR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            if (opcode == OP_STORE) begin
               state_d = ST_MEMWRITE;
            end else if (opcode == OP_LOAD) begin
               state_d = ST_MEMREAD;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            ResultSrc     = RES_MEMDATA;
            reg_write_raw = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_EXECR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_REGB;
            alu_op  = ALUOP_R_T;
            state_d = ST_ALUWB;
         end
         ST_EXECI: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_I_T;
            state_d = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_write_raw = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_BRANCH: begin
            // ALU subtracts rs1-rs2 for the flags; PC loads the target held in ALUOut.
            ALUSrcA      = SRCA_REGA;
            ALUSrcB      = SRCB_REGB;
            alu_op       = ALUOP_B_T;
            pc_write_raw = br_take;
            illegal_raw  = br_bad;
            state_d      = ST_FETCH;
         end
         ST_JAL: begin
            // PC takes the DECODE target while the ALU forms the link value OldPC+4.
            pc_write_raw = 1'b1;
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            state_d      = ST_ALUWB;
         end
         ST_JALR1: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            state_d = ST_JALR2;
         end
         ST_JALR2: begin
            pc_write_raw = 1'b1;
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            state_d      = ST_ALUWB;
         end
         ST_LUI: begin
            ResultSrc     = RES_IMMEXT;
            reg_write_raw = 1'b1;
            state_d       = ST_FETCH;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Enables are gated by reset so an aborted instruction cannot issue a write.
   assign PCWrite  = pc_write_raw  & rst;
   assign MemWrite = mem_write_raw & rst;
   assign IRWrite  = ir_write_raw  & rst;
   assign RegWrite = reg_write_raw & rst;
   assign illegal  = illegal_raw   & rst;
   assign ALUOp    = alu_op;
   assign ImmSrc   = imm_src_of(opcode);

endmodule

// File: tb/tb_multicycle_main_controller.sv
module tb_multicycle_main_controller;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       zero;
   logic       neg;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ImmSrc;
   logic [1:0] ALUOp;
   logic       illegal;

   int checks = 0;
   int errors = 0;

   multicycle_main_controller dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .func3     (func3),
      .zero      (zero),
      .neg       (neg),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ImmSrc    (ImmSrc),
      .ALUOp     (ALUOp),
      .illegal   (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output word: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal}
   logic [13:0] outs;
   assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};

   //                                   PCW   Adr   MW    IRW   RW    Res    A      B      Op     ill
   localparam logic [13:0] P_RST     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [13:0] P_FETCH   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [13:0] P_DEC     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
   localparam logic [13:0] P_DEC_ILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1};
   localparam logic [13:0] P_MADR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
   localparam logic [13:0] P_MRD     = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [13:0] P_MWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [13:0] P_MWR     = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [13:0] P_EXR     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
   localparam logic [13:0] P_EXI     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b11, 1'b0};
   localparam logic [13:0] P_AWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [13:0] P_BRT     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
   localparam logic [13:0] P_BRN     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
   localparam logic [13:0] P_BRX     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1};
   localparam logic [13:0] P_JAL     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
   localparam logic [13:0] P_JR1     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
   localparam logic [13:0] P_JR2     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
   localparam logic [13:0] P_LUI     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [13:0] P_NONE    = 14'd0;

   typedef struct packed {
      logic [6:0]       op;
      logic [2:0]       f3;
      logic             z;
      logic             n;
      logic [2:0]       len;
      logic [2:0]       imm;
      logic [4:0][13:0] exp;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic n,
                               input logic [2:0] len, input logic [2:0] imm,
                               input logic [13:0] e0, input logic [13:0] e1, input logic [13:0] e2,
                               input logic [13:0] e3, input logic [13:0] e4);
      vec_t v;
      v.op = op; v.f3 = f3; v.z = z; v.n = n; v.len = len; v.imm = imm;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
      return v;
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // add x3,x1,x2 / lw / sw / branches / illegal / jalr / jal / lui / addi / auipc(unsupported)
      vecs[0]  = mk(7'b0110011, 3'b000, 1'b0, 1'b0, 3'd4, 3'b000, P_FETCH, P_DEC, P_EXR,  P_AWB, P_NONE);
      vecs[1]  = mk(7'b0000011, 3'b010, 1'b0, 1'b0, 3'd5, 3'b000, P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB);
      vecs[2]  = mk(7'b0100011, 3'b010, 1'b0, 1'b0, 3'd4, 3'b001, P_FETCH, P_DEC, P_MADR, P_MWR, P_NONE);
      vecs[3]  = mk(7'b1100011, 3'b000, 1'b1, 1'b0, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRT,  P_NONE, P_NONE);
      vecs[4]  = mk(7'b1100011, 3'b001, 1'b1, 1'b0, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRN,  P_NONE, P_NONE);
      vecs[5]  = mk(7'b1100011, 3'b100, 1'b0, 1'b1, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRT,  P_NONE, P_NONE);
      vecs[6]  = mk(7'b1100011, 3'b101, 1'b0, 1'b1, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRN,  P_NONE, P_NONE);
      vecs[7]  = mk(7'b1100011, 3'b000, 1'b0, 1'b0, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRN,  P_NONE, P_NONE);
      vecs[8]  = mk(7'b1100011, 3'b001, 1'b0, 1'b0, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRT,  P_NONE, P_NONE);
      vecs[9]  = mk(7'b1100011, 3'b010, 1'b1, 1'b1, 3'd3, 3'b010, P_FETCH, P_DEC, P_BRX,  P_NONE, P_NONE);
      vecs[10] = mk(7'b1111111, 3'b000, 1'b0, 1'b0, 3'd2, 3'b000, P_FETCH, P_DEC_ILL, P_NONE, P_NONE, P_NONE);
      vecs[11] = mk(7'b1100111, 3'b000, 1'b0, 1'b0, 3'd5, 3'b000, P_FETCH, P_DEC, P_JR1,  P_JR2, P_AWB);
      vecs[12] = mk(7'b1101111, 3'b000, 1'b0, 1'b0, 3'd4, 3'b011, P_FETCH, P_DEC, P_JAL,  P_AWB, P_NONE);
      vecs[13] = mk(7'b0110111, 3'b000, 1'b0, 1'b0, 3'd3, 3'b100, P_FETCH, P_DEC, P_LUI,  P_NONE, P_NONE);
      vecs[14] = mk(7'b0010011, 3'b000, 1'b0, 1'b0, 3'd4, 3'b000, P_FETCH, P_DEC, P_EXI,  P_AWB, P_NONE);
      vecs[15] = mk(7'b0010111, 3'b000, 1'b0, 1'b0, 3'd2, 3'b000, P_FETCH, P_DEC_ILL, P_NONE, P_NONE, P_NONE);

      rst    = 1'b0;
      opcode = 7'd0;
      func3  = 3'd0;
      zero   = 1'b0;
      neg    = 1'b0;

      // Reset state: enables low, selects show FETCH values.
      #12;
      check("reset_outputs", outs, P_RST);
      check("reset_aluop", {12'd0, ALUOp}, 14'd0);
      step();
      check("reset_hold", outs, P_RST);
      rst = 1'b1;

      // Table-driven instruction sequences; each ends back in FETCH.
      for (int i = 0; i < NVEC; i++) begin
         opcode = vecs[i].op;
         func3  = vecs[i].f3;
         zero   = vecs[i].z;
         neg    = vecs[i].n;
         #1;
         check($sformatf("vec%0d_cyc0", i), outs, vecs[i].exp[0]);
         for (int c = 1; c < int'(vecs[i].len); c++) begin
            step();
            check($sformatf("vec%0d_cyc%0d", i, c), outs, vecs[i].exp[c]);
            if (c == 1) begin
               check($sformatf("vec%0d_immsrc", i), {11'd0, ImmSrc}, {11'd0, vecs[i].imm});
            end
         end
         step();
      end
      check("back_in_fetch", outs, P_FETCH);

      // Reset dropped during MEMWRITE of a sw: write aborts at once, state returns to FETCH.
      opcode = 7'b0100011;
      func3  = 3'b010;
      step();
      check("sw_decode", outs, P_DEC);
      step();
      check("sw_memadr", outs, P_MADR);
      step();
      check("sw_memwrite", outs, P_MWR);
      rst = 1'b0;
      #1;
      check("rst_abort_memwrite", outs, P_RST);
      step();
      check("rst_held", outs, P_RST);
      rst = 1'b1;
      #1;
      check("rst_release_fetch", outs, P_FETCH);
      step();
      check("first_irwrite_taken", outs, P_DEC);
      step();
      check("restart_memadr", outs, P_MADR);
      step();
      check("restart_memwrite", outs, P_MWR);
      step();
      check("restart_fetch", outs, P_FETCH);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
